// File: rtl/ac_e_register_pkg.sv
// Shared datapath definitions for the AC/E register slice: default width,
// AC-op priority indices and the skip-flag bundle.
package ac_e_register_pkg;

  localparam int AC_WIDTH_DEFAULT = 8;

  // AC-op indices, lowest index wins
  localparam int OP_CLA     = 0;
  localparam int OP_LDAC    = 1;
  localparam int OP_INC     = 2;
  localparam int OP_CIR     = 3;
  localparam int OP_CIL     = 4;
  localparam int NUM_AC_OPS = 5;

  typedef struct packed {
    logic pos;
    logic neg;
    logic zero;
    logic ezero;
  } ac_flags_t;

  // True when two or more request bits are set
  function automatic logic multi_hot(input logic [NUM_AC_OPS-1:0] req);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < NUM_AC_OPS; i++) begin
      cnt = cnt + {2'b00, req[i]};
    end
    return (cnt >= 3'd2);
  endfunction

endpackage

// File: rtl/ac_e_register_if.sv
// Control/data bundle between the ALU/control unit (master) and the AC/E
// register (slave).
interface ac_e_register_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] acdata;
  logic             carry;
  logic             ldac;
  logic             addop;
  logic             cla;
  logic             inc;
  logic             cir;
  logic             cil;
  logic             cle;
  logic             cme;
  logic [WIDTH-1:0] ac;
  logic             e;
  logic             ac_pos;
  logic             ac_neg;
  logic             ac_zero;
  logic             e_zero;
  logic             conflict;

  modport master (
    output acdata, carry, ldac, addop, cla, inc, cir, cil, cle, cme,
    input  ac, e, ac_pos, ac_neg, ac_zero, e_zero, conflict
  );

  modport slave (
    input  acdata, carry, ldac, addop, cla, inc, cir, cil, cle, cme,
    output ac, e, ac_pos, ac_neg, ac_zero, e_zero, conflict
  );
endinterface

// File: rtl/ac_e_register_flag_decode.sv
// Skip-test flag decode for SPA/SNA/SZA/SZE, purely combinational from the
// AC and E registers.
module ac_flag_decode
  import ac_e_register_pkg::*;
#(
  parameter int WIDTH = AC_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] ac,
  input  logic             e,
  output ac_flags_t        flags
);

  logic zero_s;

  // Derive the four skip flags
  always_comb begin
    zero_s      = (ac == {WIDTH{1'b0}});
    flags.zero  = zero_s;
    flags.neg   = ac[WIDTH-1];
    flags.pos   = ~ac[WIDTH-1] & ~zero_s;
    flags.ezero = ~e;
  end

endmodule

// File: rtl/ac_e_register.sv
// Accumulator and extended-carry storage: captures ALU results and runs the
// register-reference micro-ops in place, with a sticky op-conflict flag.
module ac_e_register
  import ac_e_register_pkg::*;
#(
  parameter int WIDTH = AC_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  ac_e_register_if.slave     bus
);

  logic [WIDTH-1:0]      ac_r;
  logic                  e_r;
  logic                  conflict_r;
  logic [WIDTH-1:0]      next_ac_s;
  logic                  next_e_s;
  logic                  e_wr_s;
  logic [NUM_AC_OPS-1:0] ac_ops_s;
  logic [NUM_AC_OPS-1:0] e_ops_s;
  logic                  conflict_set_s;
  ac_flags_t             flags_s;

  // Resolve the winning AC op and the E source for this cycle
  always_comb begin
    ac_ops_s           = '0;
    ac_ops_s[OP_CLA]   = bus.cla;
    ac_ops_s[OP_LDAC]  = bus.ldac;
    ac_ops_s[OP_INC]   = bus.inc;
    ac_ops_s[OP_CIR]   = bus.cir;
    ac_ops_s[OP_CIL]   = bus.cil;
    next_ac_s          = ac_r;
    next_e_s           = e_r;
    e_wr_s             = 1'b0;

    if (ac_ops_s[OP_CLA]) begin
      next_ac_s = {WIDTH{1'b0}};
    end else if (ac_ops_s[OP_LDAC]) begin
      next_ac_s = bus.acdata;
      if (bus.addop) begin
        next_e_s = bus.carry;
        e_wr_s   = 1'b1;
      end else begin
        e_wr_s   = 1'b0;
      end
    end else if (ac_ops_s[OP_INC]) begin
      next_ac_s = ac_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else if (ac_ops_s[OP_CIR]) begin
      next_ac_s = {e_r, ac_r[WIDTH-1:1]};
      next_e_s  = ac_r[0];
      e_wr_s    = 1'b1;
    end else if (ac_ops_s[OP_CIL]) begin
      next_ac_s = {ac_r[WIDTH-2:0], e_r};
      next_e_s  = ac_r[WIDTH-1];
      e_wr_s    = 1'b1;
    end else begin
      next_ac_s = ac_r;
    end

    // CLE/CME only reach E when the AC op left it alone
    if (e_wr_s) begin
      next_e_s = next_e_s;
    end else if (bus.cle) begin
      next_e_s = 1'b0;
    end else if (bus.cme) begin
      next_e_s = ~e_r;
    end else begin
      next_e_s = e_r;
    end

    e_ops_s        = {2'b00, e_wr_s, bus.cme, bus.cle};
    conflict_set_s = multi_hot(ac_ops_s) | multi_hot(e_ops_s);
  end

  // Register update with reset overriding all ops
  always_ff @(posedge clk) begin
    if (rst) begin
      ac_r       <= {WIDTH{1'b0}};
      e_r        <= 1'b0;
      conflict_r <= 1'b0;
    end else begin
      ac_r       <= next_ac_s;
      e_r        <= next_e_s;
      conflict_r <= conflict_r | conflict_set_s;
    end
  end

  ac_flag_decode #(.WIDTH(WIDTH)) u_flag_decode (
    .ac    (ac_r),
    .e     (e_r),
    .flags (flags_s)
  );

  assign bus.ac       = ac_r;
  assign bus.e        = e_r;
  assign bus.conflict = conflict_r;
  assign bus.ac_pos   = flags_s.pos;
  assign bus.ac_neg   = flags_s.neg;
  assign bus.ac_zero  = flags_s.zero;
  assign bus.e_zero   = flags_s.ezero;

endmodule

// File: tb/tb_ac_e_register.sv
// Directed and randomized check of ac_e_register against an arithmetic
// reference model of AC, E and the sticky conflict flag.
module tb_ac_e_register;

  localparam int W   = 8;
  localparam int MOD = 256;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   m_ac;
  int   m_e;
  int   m_cf;

  ac_e_register_if #(.WIDTH(W)) bus ();

  ac_e_register #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.acdata = 8'h00; bus.carry = 1'b0; bus.ldac = 1'b0; bus.addop = 1'b0;
    bus.cla = 1'b0; bus.inc = 1'b0; bus.cir = 1'b0; bus.cil = 1'b0;
    bus.cle = 1'b0; bus.cme = 1'b0; rst = 1'b0;
  endtask

  // One clock: predict from the rules, advance, compare every output
  task automatic tick();
    int  nac, ne, nacops, neops, ewr;
    nac = m_ac; ne = m_e; ewr = 0;
    nacops = int'(bus.cla) + int'(bus.ldac) + int'(bus.inc) + int'(bus.cir) + int'(bus.cil);
    if (bus.cla) nac = 0;
    else if (bus.ldac) begin
      nac = int'(bus.acdata);
      if (bus.addop) begin ne = int'(bus.carry); ewr = 1; end
    end
    else if (bus.inc) nac = (m_ac + 1) % MOD;
    else if (bus.cir) begin nac = m_ac / 2 + m_e * (MOD / 2); ne = m_ac % 2; ewr = 1; end
    else if (bus.cil) begin nac = (m_ac * 2) % MOD + m_e; ne = m_ac / (MOD / 2); ewr = 1; end
    if (ewr == 0) begin
      if (bus.cle) ne = 0;
      else if (bus.cme) ne = 1 - m_e;
    end
    neops = int'(bus.cle) + int'(bus.cme) + ewr;
    if (rst) begin
      nac = 0; ne = 0; m_cf = 0;
    end else if (nacops >= 2 || neops >= 2) begin
      m_cf = 1;
    end
    @(posedge clk);
    #1;
    m_ac = nac; m_e = ne;
    check("ac",       32'(bus.ac),       32'(m_ac));
    check("e",        32'(bus.e),        32'(m_e));
    check("conflict", 32'(bus.conflict), 32'(m_cf));
    check("ac_zero",  32'(bus.ac_zero),  32'(m_ac == 0));
    check("ac_neg",   32'(bus.ac_neg),   32'(m_ac >= MOD / 2));
    check("ac_pos",   32'(bus.ac_pos),   32'(m_ac > 0 && m_ac < MOD / 2));
    check("e_zero",   32'(bus.e_zero),   32'(m_e == 0));
  endtask

  task automatic load(input logic [7:0] d, input logic c);
    idle(); bus.ldac = 1'b1; bus.addop = 1'b1; bus.acdata = d; bus.carry = c;
    tick();
  endtask

  initial begin
    n_cmp = 0; n_err = 0; m_ac = 0; m_e = 0; m_cf = 0;
    idle();

    // Reset overrides a load
    rst = 1'b1; bus.ldac = 1'b1; bus.acdata = 8'h5A;
    tick();
    check("rst_ac", 32'(bus.ac), 32'h00);
    check("rst_zero", 32'(bus.ac_zero), 32'h1);
    check("rst_ezero", 32'(bus.e_zero), 32'h1);
    check("rst_conflict", 32'(bus.conflict), 32'h0);

    // ADD load then plain load
    load(8'h2C, 1'b1);
    check("add_ac", 32'(bus.ac), 32'h2C);
    check("add_e", 32'(bus.e), 32'h1);
    idle(); bus.ldac = 1'b1; bus.acdata = 8'h80; tick();
    check("ld_ac", 32'(bus.ac), 32'h80);
    check("ld_e", 32'(bus.e), 32'h1);
    check("ld_neg", 32'(bus.ac_neg), 32'h1);

    // Rotates
    load(8'h81, 1'b0);
    idle(); bus.cir = 1'b1; tick();
    check("cir_ac", 32'(bus.ac), 32'h40);
    check("cir_e", 32'(bus.e), 32'h1);
    idle(); bus.cil = 1'b1; tick();
    check("cil_ac", 32'(bus.ac), 32'h81);
    check("cil_e", 32'(bus.e), 32'h0);
    tick();
    check("cil2_ac", 32'(bus.ac), 32'h02);
    check("cil2_e", 32'(bus.e), 32'h1);

    // INC wrap
    load(8'hFF, 1'b0);
    idle(); bus.inc = 1'b1; tick();
    check("inc_wrap_ac", 32'(bus.ac), 32'h00);
    check("inc_wrap_e", 32'(bus.e), 32'h0);
    check("inc_wrap_zero", 32'(bus.ac_zero), 32'h1);
    tick();
    check("inc_ac", 32'(bus.ac), 32'h01);
    check("inc_pos", 32'(bus.ac_pos), 32'h1);

    // Simultaneous ops and sticky conflict
    load(8'h33, 1'b1);
    idle(); bus.cla = 1'b1; bus.inc = 1'b1; bus.cme = 1'b1; bus.cle = 1'b1; tick();
    check("multi_ac", 32'(bus.ac), 32'h00);
    check("multi_e", 32'(bus.e), 32'h0);
    check("multi_conflict", 32'(bus.conflict), 32'h1);
    idle();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("sticky_conflict", 32'(bus.conflict), 32'h1);
    end
    rst = 1'b1; tick();
    check("clr_conflict", 32'(bus.conflict), 32'h0);

    // Reset in the same cycle as an ADD load, then the load alone
    idle(); rst = 1'b1; bus.ldac = 1'b1; bus.addop = 1'b1; bus.acdata = 8'h7F; bus.carry = 1'b1;
    tick();
    check("midrst_ac", 32'(bus.ac), 32'h00);
    check("midrst_e", 32'(bus.e), 32'h0);
    rst = 1'b0; tick();
    check("after_rst_ac", 32'(bus.ac), 32'h7F);
    check("after_rst_e", 32'(bus.e), 32'h1);

    // Randomized ops, each op sparsely asserted so single ops dominate
    for (int i = 0; i < 400; i++) begin
      bus.acdata = 8'($urandom);
      bus.carry  = 1'($urandom);
      bus.ldac   = ($urandom_range(0, 4) == 0);
      bus.addop  = 1'($urandom);
      bus.cla    = ($urandom_range(0, 9) == 0);
      bus.inc    = ($urandom_range(0, 4) == 0);
      bus.cir    = ($urandom_range(0, 4) == 0);
      bus.cil    = ($urandom_range(0, 4) == 0);
      bus.cle    = ($urandom_range(0, 6) == 0);
      bus.cme    = ($urandom_range(0, 4) == 0);
      rst        = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
